// File: rtl/wb_pkg.sv
// Shared write-back types and constants.
// Source ids, default width and the output-stage state encoding.
package wb_pkg;

  localparam int WB_WIDTH = 32;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_mux_arbiter_mux.sv
// 2:1 write-back data mux.
// The shared datapath that the arbiter steers.
module wb_mux_arbiter_mux
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic             select,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] out
);

  assign out = select ? input1 : input0;

endmodule

// File: rtl/wb_mux_arbiter.sv
// Write-back arbiter: picks ALU or load data through the shared
// mux and holds the winner in a 1-entry stage for the RF port.
module wb_mux_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH,
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  wb_state_t        state;
  wb_state_t        state_n;
  logic             last_grant;
  logic             sel_q;
  logic             accept;
  logic             gnt_vld;
  logic             grant;
  logic [WIDTH-1:0] mux_out;

  wb_mux_arbiter_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .select(select),
    .input0(req0_data),
    .input1(req1_data),
    .out   (mux_out)
  );

  assign out_valid = (state == WB_FULL);

  // Reset gates accept so no ready escapes while reset_n is low.
  always_comb begin
    accept  = reset_n && (!out_valid || out_ready);
    gnt_vld = accept && (req0_valid || req1_valid);
    grant   = WB_SRC_ALU;
    unique case (1'b1)
      (req0_valid && req1_valid):
        grant = (RR_EN != 0) ? ~last_grant : WB_SRC_ALU;
      (req1_valid && !req0_valid):
        grant = WB_SRC_MEM;
      default:
        grant = WB_SRC_ALU;
    endcase
    select     = gnt_vld ? grant : sel_q;
    req0_ready = gnt_vld && (grant == WB_SRC_ALU);
    req1_ready = gnt_vld && (grant == WB_SRC_MEM);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WB_EMPTY: if (gnt_vld) state_n = WB_FULL;
      WB_FULL:  if (out_ready) state_n = gnt_vld ? WB_FULL : WB_EMPTY;
      default:  state_n = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= WB_EMPTY;
      out_data   <= '0;
      out_src    <= WB_SRC_ALU;
      last_grant <= WB_SRC_MEM;
      sel_q      <= WB_SRC_ALU;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      state <= state_n;
      if (gnt_vld) begin
        out_data   <= mux_out;
        out_src    <= grant;
        last_grant <= grant;
        sel_q      <= grant;
        if (grant == WB_SRC_MEM) begin
          if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end else begin
          if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mux_arbiter.sv
// Directed bench: ua is round-robin, 16-bit counters; ub is
// fixed priority with 2-bit counters for saturation.
module tb_wb_mux_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        out_ready;

  logic        a_r0, a_r1, a_sel, a_ov, a_src;
  logic [31:0] a_data;
  logic [15:0] a_c0, a_c1;

  logic        b_r0, b_r1, b_sel, b_ov, b_src;
  logic [31:0] b_data;
  logic [1:0]  b_c0, b_c1;

  int n_vec;
  int n_bad;

  wb_mux_arbiter #(.WIDTH(32), .RR_EN(1), .CNT_W(16)) ua (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1),
    .select(a_sel), .out_valid(a_ov), .out_data(a_data), .out_src(a_src),
    .out_ready(out_ready), .grant_cnt0(a_c0), .grant_cnt1(a_c1)
  );

  wb_mux_arbiter #(.WIDTH(32), .RR_EN(0), .CNT_W(2)) ub (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
    .select(b_sel), .out_valid(b_ov), .out_data(b_data), .out_src(b_src),
    .out_ready(out_ready), .grant_cnt0(b_c0), .grant_cnt1(b_c1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 32'h5;
    req1_valid = 1'b1;
    req1_data  = 32'h6;
    out_ready  = 1'b1;
    #1;
    chk("rst_r0_comb", {31'b0, a_r0}, 32'h0);
    chk("rst_r1_comb", {31'b0, a_r1}, 32'h0);
    tick();
    tick();
    chk("rst_r0", {31'b0, a_r0}, 32'h0);
    chk("rst_r1", {31'b0, a_r1}, 32'h0);
    chk("rst_ov", {31'b0, a_ov}, 32'h0);
    chk("rst_data", a_data, 32'h0);
    chk("rst_c0", {16'b0, a_c0}, 32'h0);
    chk("rst_c1", {16'b0, a_c1}, 32'h0);
    chk("rst_b_ov", {31'b0, b_ov}, 32'h0);

    // single request from port 0
    reset_n    = 1'b1;
    req1_valid = 1'b0;
    #1;
    chk("single_r0", {31'b0, a_r0}, 32'h1);
    chk("single_r1", {31'b0, a_r1}, 32'h0);
    chk("single_sel", {31'b0, a_sel}, 32'h0);
    tick();
    req0_valid = 1'b0;
    chk("single_ov", {31'b0, a_ov}, 32'h1);
    chk("single_data", a_data, 32'h5);
    chk("single_src", {31'b0, a_src}, 32'h0);
    chk("single_c0", {16'b0, a_c0}, 32'h1);
    tick();
    chk("drain_ov", {31'b0, a_ov}, 32'h0);

    // round-robin conflict, fresh last_grant
    rst_pulse();
    req0_valid = 1'b1;
    req0_data  = 32'hA;
    req1_valid = 1'b1;
    req1_data  = 32'hB;
    #1;
    chk("rr0_r0", {31'b0, a_r0}, 32'h1);
    tick();
    chk("rr0_data", a_data, 32'hA);
    chk("rr1_r1", {31'b0, a_r1}, 32'h1);
    chk("rr1_sel", {31'b0, a_sel}, 32'h1);
    tick();
    chk("rr1_data", a_data, 32'hB);
    chk("rr2_r0", {31'b0, a_r0}, 32'h1);
    tick();
    chk("rr2_data", a_data, 32'hA);
    tick();
    chk("rr3_data", a_data, 32'hB);
    chk("rr3_src", {31'b0, a_src}, 32'h1);
    chk("rr_c0", {16'b0, a_c0}, 32'h2);
    chk("rr_c1", {16'b0, a_c1}, 32'h2);

    // stall while FULL holding B
    req1_valid = 1'b0;
    req0_data  = 32'hC;
    out_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_r0", {31'b0, a_r0}, 32'h0);
      chk("stall_r1", {31'b0, a_r1}, 32'h0);
      tick();
      chk("stall_data", a_data, 32'hB);
      chk("stall_ov", {31'b0, a_ov}, 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_r0", {31'b0, a_r0}, 32'h1);
    tick();
    chk("rel_data", a_data, 32'hC);
    chk("rel_src", {31'b0, a_src}, 32'h0);
    chk("rel_c0", {16'b0, a_c0}, 32'h3);
    req0_valid = 1'b0;
    tick();
    chk("rel_empty", {31'b0, a_ov}, 32'h0);

    // fixed priority on ub
    rst_pulse();
    req0_valid = 1'b1;
    req0_data  = 32'hA;
    req1_valid = 1'b1;
    req1_data  = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_r0", {31'b0, b_r0}, 32'h1);
      chk("fp_r1", {31'b0, b_r1}, 32'h0);
      tick();
      chk("fp_data", b_data, 32'hA);
      chk("fp_c1", {30'b0, b_c1}, 32'h0);
    end
    chk("fp_c0_sat", {30'b0, b_c0}, 32'h3);

    // port-1 only: 2-bit counter saturates
    req0_valid = 1'b0;
    req1_data  = 32'hD;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_c1", {30'b0, b_c1}, 32'h3);
    chk("sat_data", b_data, 32'hD);
    chk("sat_src", {31'b0, b_src}, 32'h1);
    chk("sat_ov", {31'b0, b_ov}, 32'h1);

    // reset while FULL
    out_ready  = 1'b0;
    req0_valid = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("mrst_r0", {31'b0, b_r0}, 32'h0);
    chk("mrst_r1", {31'b0, b_r1}, 32'h0);
    tick();
    chk("mrst_ov", {31'b0, b_ov}, 32'h0);
    chk("mrst_data", b_data, 32'h0);
    chk("mrst_c1", {30'b0, b_c1}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
